// File: rtl/mul_acc_pkg.sv
// ============================================================================
// Module  : mul_acc_pkg
// Brief   : Shared types and default constants for the multiplier MAC back end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_acc_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   localparam int PROD_W_DEF = 8;
   localparam int ACC_W_DEF  = 12;
   localparam int COUNT_DEF  = 4;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ready_rise_det.sv
// ============================================================================
// Module  : ready_rise_det
// Brief   : Rising-edge detector on the multiplier ready level (one cap per high).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ready_rise_det (
   input  logic clk,
   input  logic reset,
   input  logic ready_in,
   output logic cap
);

   logic ready_d;

   // Resetting to 1 keeps a ready already high at reset release from counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_d <= 1'b1;
      end else begin
         ready_d <= ready_in;
      end
   end

   assign cap = ready_in & ~ready_d;

endmodule

`default_nettype wire

// File: rtl/mul_acc_collector.sv
// ============================================================================
// Module  : mul_acc_collector
// Brief   : Sums COUNT multiplier products per group, emits sum, valid, overflow.
//           Define MUL_ACC_SAT_EN to clamp on overflow instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_acc_collector
   import mul_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int COUNT  = COUNT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              ready_in,
   input  logic [PROD_W-1:0] product_in,
   input  logic              sign_in,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   output logic              overflow,
   output logic              busy
);

   localparam int              CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

   logic             cap;
   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             mode;
   logic             ovf_sticky;

   logic             cur_mode;
   logic [ACC_W-1:0] ext;
   logic [ACC_W:0]   raw;
   logic             add_ovf;
   logic [ACC_W-1:0] sum;

   ready_rise_det u_rise (
      .clk      (clk),
      .reset    (reset),
      .ready_in (ready_in),
      .cap      (cap)
   );

   always_comb begin
      // Mode is taken live on the first capture, latched for the rest of the group.
      cur_mode = (state == IDLE) ? sign_in : mode;
      if (cur_mode == MODE_SIGNED) begin
         ext = {{(ACC_W - PROD_W){product_in[PROD_W-1]}}, product_in};
      end else begin
         ext = {{(ACC_W - PROD_W){1'b0}}, product_in};
      end
      raw = {1'b0, acc} + {1'b0, ext};
      if (cur_mode == MODE_SIGNED) begin
         add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
      end else begin
         add_ovf = raw[ACC_W];
      end
      sum = raw[ACC_W-1:0];
`ifdef MUL_ACC_SAT_EN
      if (add_ovf) begin
         if (cur_mode == MODE_SIGNED) begin
            sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end else begin
            sum = {ACC_W{1'b1}};
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         acc        <= '0;
         count      <= '0;
         mode       <= MODE_UNSIGNED;
         ovf_sticky <= 1'b0;
         acc_out    <= '0;
         acc_valid  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         acc_valid <= 1'b0;
         if (clear) begin
            state      <= IDLE;
            acc        <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
         end else if (cap) begin
            case (state)
               IDLE: begin
                  if (COUNT == 1) begin
                     acc_out   <= ext;
                     overflow  <= 1'b0;
                     acc_valid <= 1'b1;
                  end else begin
                     acc        <= ext;
                     count      <= CNT_W'(1);
                     mode       <= sign_in;
                     ovf_sticky <= 1'b0;
                     state      <= ACC;
                  end
               end
               ACC: begin
                  if (count == LAST) begin
                     acc_out    <= sum;
                     overflow   <= ovf_sticky | add_ovf;
                     acc_valid  <= 1'b1;
                     acc        <= '0;
                     count      <= '0;
                     ovf_sticky <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     acc        <= sum;
                     count      <= count + CNT_W'(1);
                     ovf_sticky <= ovf_sticky | add_ovf;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state == ACC);

endmodule

`default_nettype wire
